// File: rtl/spmv_mem_model.sv
// spmv_mem_model: shared-array main-memory responder for SpMV processing elements.
// Each channel has its own fixed-latency load pipeline, response FIFO and
// credit-based request stall; all channels read and write one common word array.
module spmv_mem_model #(
   parameter int NUM_CH     = 1,
   parameter int ADDR_W     = 48,
   parameter int DATA_W     = 64,
   parameter int TAG_W      = 3,
   parameter int MEM_LOG2   = 12,
   parameter int LATENCY    = 1,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_CH-1:0]          req_ld,
   input  logic [NUM_CH-1:0]          req_st,
   input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
   input  logic [NUM_CH*DATA_W-1:0]   req_d_or_tag,
   output logic [NUM_CH-1:0]          req_stall,
   output logic [NUM_CH-1:0]          rsp_push,
   output logic [NUM_CH*TAG_W-1:0]    rsp_tag,
   output logic [NUM_CH*DATA_W-1:0]   rsp_q,
   input  logic [NUM_CH-1:0]          rsp_stall,
   output logic                       err_oob
);

   localparam int MEM_WORDS = 1 << MEM_LOG2;
   localparam int PTR_W     = $clog2(FIFO_DEPTH);
   localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
   localparam int HI_W      = ADDR_W - 3 - MEM_LOG2;

   // Shared word array; deliberately never cleared so contents survive reset.
   logic [DATA_W-1:0] mem [MEM_WORDS];

   logic [NUM_CH-1:0]          acc_ld;
   logic [NUM_CH-1:0]          acc_st;
   logic [NUM_CH-1:0]          oob;
   logic [NUM_CH*MEM_LOG2-1:0] idx_all;
   logic [NUM_CH*3-1:0]        unused_addr_lsb;
   logic                       err_oob_q;

   // Stores commit at the accept edge; the ascending loop makes the highest channel win a same-word collision.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (acc_st[c] && !oob[c]) begin
            mem[idx_all[c*MEM_LOG2 +: MEM_LOG2]] <= req_d_or_tag[c*DATA_W +: DATA_W];
         end
      end
   end

   // Sticky out-of-range flag, set by any accepted load or store past the array end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_oob_q <= 1'b0;
      end else if (|((acc_ld | acc_st) & oob)) begin
         err_oob_q <= 1'b1;
      end
   end

   assign err_oob = err_oob_q;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [MEM_LOG2-1:0] idx;
         logic [DATA_W-1:0]   rd_data;
         logic                stall_q;
         logic                sr_vld_q    [LATENCY];
         logic [TAG_W-1:0]    sr_tag_q    [LATENCY];
         logic [DATA_W-1:0]   sr_data_q   [LATENCY];
         logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
         logic [TAG_W-1:0]    fifo_tag_q  [FIFO_DEPTH];
         logic [PTR_W-1:0]    wr_ptr_q;
         logic [PTR_W-1:0]    rd_ptr_q;
         logic [CNT_W-1:0]    cnt_q;
         logic [CNT_W-1:0]    cnt_d;
         logic [CNT_W-1:0]    outst_q;
         logic [CNT_W-1:0]    outst_d;
         logic                push;
         logic                pop;
         logic                rsp_push_q;
         logic [TAG_W-1:0]    rsp_tag_q;
         logic [DATA_W-1:0]   rsp_data_q;

         // Address decode: word index from bits above the byte offset, anything higher is out of range.
         assign idx                         = req_addr[gi*ADDR_W+3 +: MEM_LOG2];
         assign oob[gi]                     = |req_addr[gi*ADDR_W+3+MEM_LOG2 +: HI_W];
         assign idx_all[gi*MEM_LOG2 +: MEM_LOG2] = idx;
         assign unused_addr_lsb[gi*3 +: 3]  = req_addr[gi*ADDR_W +: 3];

         // A simultaneous load+store is a store; nothing is accepted while stalled.
         assign acc_st[gi] = req_st[gi] & ~stall_q;
         assign acc_ld[gi] = req_ld[gi] & ~req_st[gi] & ~stall_q;

         // Combinational read sampled at the accept edge gives read-before-write against same-cycle stores.
         assign rd_data = oob[gi] ? '0 : mem[idx];

         assign push    = sr_vld_q[LATENCY-1];
         assign pop     = (cnt_q != '0) && !rsp_stall[gi];
         assign cnt_d   = cnt_q + CNT_W'(push) - CNT_W'(pop);
         // Outstanding loads = shift-register loads + FIFO entries; a load retires when popped.
         assign outst_d = outst_q + CNT_W'(acc_ld[gi]) - CNT_W'(pop);

         // Fixed-latency load pipeline carrying tag and read data toward the response FIFO.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int s = 0; s < LATENCY; s++) begin
                  sr_vld_q[s]  <= 1'b0;
                  sr_tag_q[s]  <= '0;
                  sr_data_q[s] <= '0;
               end
            end else begin
               sr_vld_q[0]  <= acc_ld[gi];
               sr_tag_q[0]  <= req_d_or_tag[gi*DATA_W +: TAG_W];
               sr_data_q[0] <= rd_data;
               for (int s = 1; s < LATENCY; s++) begin
                  sr_vld_q[s]  <= sr_vld_q[s-1];
                  sr_tag_q[s]  <= sr_tag_q[s-1];
                  sr_data_q[s] <= sr_data_q[s-1];
               end
            end
         end

         // FIFO storage, written at the tail as a load leaves the pipeline.
         always_ff @(posedge clk) begin
            if (push) begin
               fifo_data_q[wr_ptr_q] <= sr_data_q[LATENCY-1];
               fifo_tag_q[wr_ptr_q]  <= sr_tag_q[LATENCY-1];
            end
         end

         // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
               cnt_q    <= '0;
            end else begin
               if (push) begin
                  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
               end
               if (pop) begin
                  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
               end
               cnt_q <= cnt_d;
            end
         end

         // Registered response port: one-cycle pulse per popped word, zeros otherwise.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rsp_push_q <= 1'b0;
               rsp_tag_q  <= '0;
               rsp_data_q <= '0;
            end else if (pop) begin
               rsp_push_q <= 1'b1;
               rsp_tag_q  <= fifo_tag_q[rd_ptr_q];
               rsp_data_q <= fifo_data_q[rd_ptr_q];
            end else begin
               rsp_push_q <= 1'b0;
               rsp_tag_q  <= '0;
               rsp_data_q <= '0;
            end
         end

         // Credit tracking: stall once at most one credit remains, leaving room for a load accepted as stall rises.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               outst_q <= '0;
               stall_q <= 1'b0;
            end else begin
               outst_q <= outst_d;
               stall_q <= (outst_d >= CNT_W'(FIFO_DEPTH - 1));
            end
         end

         a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
            !(push && !pop && (cnt_q == CNT_W'(FIFO_DEPTH))))
            else $error("spmv_mem_model: response FIFO overflow on channel %0d", gi);

         assign req_stall[gi]                = stall_q;
         assign rsp_push[gi]                 = rsp_push_q;
         assign rsp_tag[gi*TAG_W +: TAG_W]   = rsp_tag_q;
         assign rsp_q[gi*DATA_W +: DATA_W]   = rsp_data_q;
      end
   endgenerate

endmodule

// File: tb/tb_spmv_mem_model.sv
// Directed self-checking bench for spmv_mem_model with two channels and a
// two-stage load pipeline.
module tb_spmv_mem_model;

   localparam int NUM_CH     = 2;
   localparam int ADDR_W     = 48;
   localparam int DATA_W     = 64;
   localparam int TAG_W      = 3;
   localparam int MEM_LOG2   = 12;
   localparam int LATENCY    = 2;
   localparam int FIFO_DEPTH = 8;
   localparam int RSP_BUDGET = 40;

   logic                     clk   = 1'b0;
   logic                     rst_n = 1'b1;
   logic [NUM_CH-1:0]        req_ld;
   logic [NUM_CH-1:0]        req_st;
   logic [NUM_CH*ADDR_W-1:0] req_addr;
   logic [NUM_CH*DATA_W-1:0] req_d_or_tag;
   logic [NUM_CH-1:0]        req_stall;
   logic [NUM_CH-1:0]        rsp_push;
   logic [NUM_CH*TAG_W-1:0]  rsp_tag;
   logic [NUM_CH*DATA_W-1:0] rsp_q;
   logic [NUM_CH-1:0]        rsp_stall;
   logic                     err_oob;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   spmv_mem_model #(
      .NUM_CH    (NUM_CH),
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .TAG_W     (TAG_W),
      .MEM_LOG2  (MEM_LOG2),
      .LATENCY   (LATENCY),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_ld      (req_ld),
      .req_st      (req_st),
      .req_addr    (req_addr),
      .req_d_or_tag(req_d_or_tag),
      .req_stall   (req_stall),
      .rsp_push    (rsp_push),
      .rsp_tag     (rsp_tag),
      .rsp_q       (rsp_q),
      .rsp_stall   (rsp_stall),
      .err_oob     (err_oob)
   );

   function automatic logic [DATA_W-1:0] q_of(input int c);
      return rsp_q[c*DATA_W +: DATA_W];
   endfunction

   function automatic logic [TAG_W-1:0] tag_of(input int c);
      return rsp_tag[c*TAG_W +: TAG_W];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_ld       = '0;
      req_st       = '0;
      req_addr     = '0;
      req_d_or_tag = '0;
   endtask

   task automatic set_req(input int c, input logic ld, input logic st,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] d);
      req_ld[c]                         = ld;
      req_st[c]                         = st;
      req_addr[c*ADDR_W +: ADDR_W]      = addr;
      req_d_or_tag[c*DATA_W +: DATA_W]  = d;
   endtask

   task automatic do_store(input int c, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] d);
      set_req(c, 1'b0, 1'b1, addr, d);
      tick();
      idle();
   endtask

   task automatic do_load(input int c, input logic [ADDR_W-1:0] addr, input int tag);
      set_req(c, 1'b1, 1'b0, addr, DATA_W'(tag));
      tick();
      idle();
   endtask

   // Cycles until rsp_push[c] is seen, or -1 when the budget runs out.
   task automatic wait_rsp(input int c, output int n);
      n = -1;
      for (int i = 1; i <= RSP_BUDGET; i++) begin
         tick();
         if (rsp_push[c]) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic count_pushes(input int c, input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (rsp_push[c]) n++;
      end
   endtask

   task automatic test_reset();
      idle();
      rsp_stall = '0;
      #2 rst_n = 1'b0;
      repeat (3) tick();
      checks++;
      if (req_stall !== 2'b00) begin failures++; $display("FAIL reset_req_stall: got %b expected 00", req_stall); end
      checks++;
      if (rsp_push !== 2'b00) begin failures++; $display("FAIL reset_rsp_push: got %b expected 00", rsp_push); end
      checks++;
      if (rsp_tag !== '0) begin failures++; $display("FAIL reset_rsp_tag: got %h expected 0", rsp_tag); end
      checks++;
      if (rsp_q !== '0) begin failures++; $display("FAIL reset_rsp_q: got %h expected 0", rsp_q); end
      checks++;
      if (err_oob !== 1'b0) begin failures++; $display("FAIL reset_err_oob: got %b expected 0", err_oob); end
      rst_n = 1'b1;
      tick();
      checks++;
      if (rsp_push !== 2'b00 || req_stall !== 2'b00) begin
         failures++; $display("FAIL reset_release: push=%b stall=%b expected 00/00", rsp_push, req_stall);
      end
      $display("test_reset done");
   endtask

   task automatic test_store_load();
      int n;
      do_store(0, 48'h40, 64'hDEAD_BEEF);
      do_load(0, 48'h40, 5);
      wait_rsp(0, n);
      checks++;
      if (n != LATENCY + 1) begin failures++; $display("FAIL store_load_latency: got %0d expected %0d", n, LATENCY + 1); end
      checks++;
      if (q_of(0) !== 64'hDEAD_BEEF) begin failures++; $display("FAIL store_load_data: got %h expected deadbeef", q_of(0)); end
      checks++;
      if (tag_of(0) !== 3'd5) begin failures++; $display("FAIL store_load_tag: got %0d expected 5", tag_of(0)); end
      tick();
      checks++;
      if (rsp_push[0] !== 1'b0 || q_of(0) !== '0 || tag_of(0) !== '0) begin
         failures++; $display("FAIL store_load_pulse: push=%b q=%h tag=%0d expected 0/0/0", rsp_push[0], q_of(0), tag_of(0));
      end
      $display("test_store_load latency=%0d q=%h", n, 64'hDEAD_BEEF);
   endtask

   task automatic test_ld_st_both();
      int n;
      set_req(0, 1'b1, 1'b1, 48'h100, 64'h55);
      tick();
      idle();
      count_pushes(0, 6, n);
      checks++;
      if (n != 0) begin failures++; $display("FAIL ldst_no_rsp: got %0d responses expected 0", n); end
      do_load(0, 48'h100, 4);
      wait_rsp(0, n);
      checks++;
      if (n < 0 || q_of(0) !== 64'h55 || tag_of(0) !== 3'd4) begin
         failures++; $display("FAIL ldst_store_taken: n=%0d q=%h tag=%0d expected q=55 tag=4", n, q_of(0), tag_of(0));
      end
      $display("test_ld_st_both done");
   endtask

   task automatic test_same_cycle();
      int n;
      do_store(0, 48'h80, 64'h22);
      set_req(0, 1'b1, 1'b0, 48'h80, 64'd1);
      set_req(1, 1'b0, 1'b1, 48'h80, 64'h11);
      tick();
      idle();
      wait_rsp(0, n);
      checks++;
      if (n < 0 || q_of(0) !== 64'h22 || tag_of(0) !== 3'd1) begin
         failures++; $display("FAIL same_cycle_old: n=%0d q=%h tag=%0d expected q=22 tag=1", n, q_of(0), tag_of(0));
      end
      do_load(0, 48'h80, 2);
      wait_rsp(0, n);
      checks++;
      if (n < 0 || q_of(0) !== 64'h11 || tag_of(0) !== 3'd2) begin
         failures++; $display("FAIL same_cycle_new: n=%0d q=%h tag=%0d expected q=11 tag=2", n, q_of(0), tag_of(0));
      end
      $display("test_same_cycle done");
   endtask

   task automatic test_same_word();
      int n;
      set_req(0, 1'b0, 1'b1, 48'h0, 64'hA);
      set_req(1, 1'b0, 1'b1, 48'h0, 64'hB);
      tick();
      idle();
      set_req(0, 1'b1, 1'b0, 48'h0, 64'd6);
      set_req(1, 1'b1, 1'b0, 48'h0, 64'd7);
      tick();
      idle();
      wait_rsp(0, n);
      checks++;
      if (n < 0 || q_of(0) !== 64'hB || tag_of(0) !== 3'd6) begin
         failures++; $display("FAIL same_word_ch0: n=%0d q=%h tag=%0d expected q=b tag=6", n, q_of(0), tag_of(0));
      end
      checks++;
      if (rsp_push[1] !== 1'b1 || q_of(1) !== 64'hB || tag_of(1) !== 3'd7) begin
         failures++; $display("FAIL same_word_ch1: push=%b q=%h tag=%0d expected 1/b/7", rsp_push[1], q_of(1), tag_of(1));
      end
      $display("test_same_word done");
   endtask

   task automatic test_max_addr();
      int n;
      do_store(0, 48'h7FF8, 64'h1234_5678_9ABC_DEF0);
      do_load(0, 48'h7FF8, 2);
      wait_rsp(0, n);
      checks++;
      if (n < 0 || q_of(0) !== 64'h1234_5678_9ABC_DEF0) begin
         failures++; $display("FAIL max_addr_data: n=%0d q=%h expected 123456789abcdef0", n, q_of(0));
      end
      checks++;
      if (err_oob !== 1'b0) begin failures++; $display("FAIL max_addr_err: got %b expected 0", err_oob); end
      $display("test_max_addr done");
   endtask

   task automatic test_oob();
      int n;
      do_load(0, 48'h8000, 3);
      wait_rsp(0, n);
      checks++;
      if (n < 0 || q_of(0) !== '0 || tag_of(0) !== 3'd3) begin
         failures++; $display("FAIL oob_load: n=%0d q=%h tag=%0d expected q=0 tag=3", n, q_of(0), tag_of(0));
      end
      checks++;
      if (err_oob !== 1'b1) begin failures++; $display("FAIL oob_err_set: got %b expected 1", err_oob); end
      do_store(1, 48'h8040, 64'hBAD);
      do_load(0, 48'h40, 1);
      wait_rsp(0, n);
      checks++;
      if (n < 0 || q_of(0) !== 64'hDEAD_BEEF) begin
         failures++; $display("FAIL oob_store_discard: n=%0d q=%h expected deadbeef", n, q_of(0));
      end
      checks++;
      if (err_oob !== 1'b1) begin failures++; $display("FAIL oob_err_sticky: got %b expected 1", err_oob); end
      $display("test_oob done");
   endtask

   task automatic test_backpressure();
      int  k;
      int  got_n;
      int  saw_push;
      logic accepted_now;
      logic [TAG_W-1:0] got [FIFO_DEPTH];
      rsp_stall = 2'b01;
      k         = 0;
      saw_push  = 0;
      for (int cyc = 0; cyc < 16; cyc++) begin
         if (k < 8) begin
            set_req(0, 1'b1, 1'b0, 48'h40, DATA_W'(k));
            accepted_now = !req_stall[0];
         end else begin
            idle();
            accepted_now = 1'b0;
         end
         tick();
         if (accepted_now) k++;
         if (rsp_push[0]) saw_push++;
      end
      idle();
      checks++;
      if (k != FIFO_DEPTH - 1) begin failures++; $display("FAIL bp_accepted: got %0d expected %0d", k, FIFO_DEPTH - 1); end
      checks++;
      if (req_stall[0] !== 1'b1) begin failures++; $display("FAIL bp_stall_high: got %b expected 1", req_stall[0]); end
      checks++;
      if (saw_push != 0) begin failures++; $display("FAIL bp_held: got %0d responses expected 0", saw_push); end
      rsp_stall = 2'b00;
      got_n = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (rsp_push[0]) begin
            if (got_n < FIFO_DEPTH) got[got_n] = tag_of(0);
            got_n++;
         end
      end
      checks++;
      if (got_n != k) begin failures++; $display("FAIL bp_returned: got %0d expected %0d", got_n, k); end
      for (int i = 0; i < got_n && i < FIFO_DEPTH; i++) begin
         checks++;
         if (got[i] !== TAG_W'(i)) begin failures++; $display("FAIL bp_order[%0d]: got %0d expected %0d", i, got[i], i); end
      end
      checks++;
      if (req_stall[0] !== 1'b0) begin failures++; $display("FAIL bp_stall_low: got %b expected 0", req_stall[0]); end
      $display("test_backpressure accepted=%0d returned=%0d", k, got_n);
   endtask

   task automatic test_reset_midburst();
      int n;
      for (int t = 0; t < 4; t++) begin
         set_req(0, 1'b1, 1'b0, 48'h40, DATA_W'(t));
         tick();
      end
      idle();
      checks++;
      if (rsp_push[0] !== 1'b1 || tag_of(0) !== 3'd0) begin
         failures++; $display("FAIL midburst_first: push=%b tag=%0d expected 1/0", rsp_push[0], tag_of(0));
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (rsp_push !== 2'b00 || rsp_q !== '0 || rsp_tag !== '0) begin
         failures++; $display("FAIL midburst_async: push=%b q=%h tag=%h expected zeros", rsp_push, rsp_q, rsp_tag);
      end
      checks++;
      if (err_oob !== 1'b0 || req_stall !== 2'b00) begin
         failures++; $display("FAIL midburst_flags: err=%b stall=%b expected 0/00", err_oob, req_stall);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      count_pushes(0, 10, n);
      checks++;
      if (n != 0) begin failures++; $display("FAIL midburst_dropped: got %0d responses expected 0", n); end
      do_load(0, 48'h40, 1);
      wait_rsp(0, n);
      checks++;
      if (n < 0 || q_of(0) !== 64'hDEAD_BEEF) begin
         failures++; $display("FAIL midburst_retain40: n=%0d q=%h expected deadbeef", n, q_of(0));
      end
      do_load(1, 48'h0, 2);
      wait_rsp(1, n);
      checks++;
      if (n < 0 || q_of(1) !== 64'hB) begin
         failures++; $display("FAIL midburst_retain0: n=%0d q=%h expected b", n, q_of(1));
      end
      $display("test_reset_midburst done");
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_ld_st_both();
      test_same_cycle();
      test_same_word();
      test_max_addr();
      test_oob();
      test_backpressure();
      test_reset_midburst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
